// File: rtl/axi4_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi4_wr_arbiter
// Description : Two-master to one-slave arbiter for the AXI4 write path
//               (AW, W, B). Round-robin grant, one write transaction in
//               flight. The granted master's AW and W channels are forwarded
//               downstream. The B response is routed back to that master.
// Ports       : clock, reset      - system clock, synchronous active-high reset
//               S0_* / S1_*       - upstream master write channels (AW, W, B)
//               M_*               - downstream slave write channels (AW, W, B)
//               busy              - transaction in progress (state not IDLE)
//               err_len           - sticky: WLAST not on beat AWLEN+1
//               err_id            - sticky: returned BID differs from granted AWID
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_wr_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    // master 0
    input  logic [ID_WIDTH-1:0]     S0_AWID,
    input  logic [ADDR_WIDTH-1:0]   S0_AWADDR,
    input  logic [7:0]              S0_AWLEN,
    input  logic [2:0]              S0_AWSIZE,
    input  logic [1:0]              S0_AWBURST,
    input  logic                    S0_AWVALID,
    output logic                    S0_AWREADY,
    input  logic [DATA_WIDTH-1:0]   S0_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S0_WSTRB,
    input  logic                    S0_WLAST,
    input  logic                    S0_WVALID,
    output logic                    S0_WREADY,
    output logic [ID_WIDTH-1:0]     S0_BID,
    output logic [1:0]              S0_BRESP,
    output logic                    S0_BVALID,
    input  logic                    S0_BREADY,
    // master 1
    input  logic [ID_WIDTH-1:0]     S1_AWID,
    input  logic [ADDR_WIDTH-1:0]   S1_AWADDR,
    input  logic [7:0]              S1_AWLEN,
    input  logic [2:0]              S1_AWSIZE,
    input  logic [1:0]              S1_AWBURST,
    input  logic                    S1_AWVALID,
    output logic                    S1_AWREADY,
    input  logic [DATA_WIDTH-1:0]   S1_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S1_WSTRB,
    input  logic                    S1_WLAST,
    input  logic                    S1_WVALID,
    output logic                    S1_WREADY,
    output logic [ID_WIDTH-1:0]     S1_BID,
    output logic [1:0]              S1_BRESP,
    output logic                    S1_BVALID,
    input  logic                    S1_BREADY,
    // downstream slave
    output logic [ID_WIDTH-1:0]     M_AWID,
    output logic [ADDR_WIDTH-1:0]   M_AWADDR,
    output logic [7:0]              M_AWLEN,
    output logic [2:0]              M_AWSIZE,
    output logic [1:0]              M_AWBURST,
    output logic                    M_AWVALID,
    input  logic                    M_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_WSTRB,
    output logic                    M_WLAST,
    output logic                    M_WVALID,
    input  logic                    M_WREADY,
    input  logic [ID_WIDTH-1:0]     M_BID,
    input  logic [1:0]              M_BRESP,
    input  logic                    M_BVALID,
    output logic                    M_BREADY,
    // status
    output logic                    busy,
    output logic                    err_len,
    output logic                    err_id
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ADDR = 2'd1;
    localparam logic [1:0] c_ST_DATA = 2'd2;
    localparam logic [1:0] c_ST_RESP = 2'd3;

    logic [1:0]          r_state;
    logic                r_grant;
    logic                r_last_grant;
    logic [7:0]          r_beat;
    logic [ID_WIDTH-1:0] r_awid;
    logic [7:0]          r_awlen;
    logic                r_err_len;
    logic                r_err_id;

    logic w_in_addr;
    logic w_in_data;
    logic w_in_resp;
    logic w_sg_awvalid;
    logic w_sg_wvalid;
    logic w_sg_wlast;
    logic w_sg_bready;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;

    assign w_in_addr = (r_state == c_ST_ADDR);
    assign w_in_data = (r_state == c_ST_DATA);
    assign w_in_resp = (r_state == c_ST_RESP);

    // Granted-master views of the handshake inputs
    assign w_sg_awvalid = r_grant ? S1_AWVALID : S0_AWVALID;
    assign w_sg_wvalid  = r_grant ? S1_WVALID  : S0_WVALID;
    assign w_sg_wlast   = r_grant ? S1_WLAST   : S0_WLAST;
    assign w_sg_bready  = r_grant ? S1_BREADY  : S0_BREADY;

    assign w_aw_hs = w_in_addr & w_sg_awvalid & M_AWREADY;
    assign w_w_hs  = w_in_data & w_sg_wvalid  & M_WREADY;
    assign w_b_hs  = w_in_resp & M_BVALID     & w_sg_bready;

    // Payload fields follow the grant unconditionally; only VALID/READY are
    // qualified by state, so no extra gating sits in the data path.
    assign M_AWID    = r_grant ? S1_AWID    : S0_AWID;
    assign M_AWADDR  = r_grant ? S1_AWADDR  : S0_AWADDR;
    assign M_AWLEN   = r_grant ? S1_AWLEN   : S0_AWLEN;
    assign M_AWSIZE  = r_grant ? S1_AWSIZE  : S0_AWSIZE;
    assign M_AWBURST = r_grant ? S1_AWBURST : S0_AWBURST;
    assign M_AWVALID = w_in_addr & w_sg_awvalid;
    assign S0_AWREADY = w_in_addr & ~r_grant & M_AWREADY;
    assign S1_AWREADY = w_in_addr &  r_grant & M_AWREADY;

    assign M_WDATA  = r_grant ? S1_WDATA : S0_WDATA;
    assign M_WSTRB  = r_grant ? S1_WSTRB : S0_WSTRB;
    assign M_WLAST  = w_sg_wlast;
    assign M_WVALID = w_in_data & w_sg_wvalid;
    assign S0_WREADY = w_in_data & ~r_grant & M_WREADY;
    assign S1_WREADY = w_in_data &  r_grant & M_WREADY;

    assign S0_BID    = M_BID;
    assign S0_BRESP  = M_BRESP;
    assign S1_BID    = M_BID;
    assign S1_BRESP  = M_BRESP;
    assign S0_BVALID = w_in_resp & ~r_grant & M_BVALID;
    assign S1_BVALID = w_in_resp &  r_grant & M_BVALID;
    assign M_BREADY  = w_in_resp & w_sg_bready;

    assign busy    = (r_state != c_ST_IDLE);
    assign err_len = r_err_len;
    assign err_id  = r_err_id;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;   // master 0 wins the first contested round
            r_beat       <= 8'd0;
            r_awid       <= '0;
            r_awlen      <= 8'd0;
            r_err_len    <= 1'b0;
            r_err_id     <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (S0_AWVALID | S1_AWVALID) begin
                        // Contested: the master that did not go last wins
                        r_grant <= (S0_AWVALID & S1_AWVALID) ? ~r_last_grant : S1_AWVALID;
                        r_state <= c_ST_ADDR;
                    end
                end
                c_ST_ADDR: begin
                    if (w_aw_hs) begin
                        r_awid  <= M_AWID;
                        r_awlen <= M_AWLEN;
                        r_beat  <= 8'd0;
                        r_state <= c_ST_DATA;
                    end
                end
                c_ST_DATA: begin
                    if (w_w_hs) begin
                        r_beat <= r_beat + 8'd1;
                        if (w_sg_wlast) begin
                            if (r_beat != r_awlen) begin
                                r_err_len <= 1'b1;
                            end
                            r_state <= c_ST_RESP;
                        end else if (r_beat == r_awlen) begin
                            // Final expected beat without WLAST; keep going until WLAST
                            r_err_len <= 1'b1;
                        end
                    end
                end
                c_ST_RESP: begin
                    if (w_b_hs) begin
                        if (M_BID != r_awid) begin
                            r_err_id <= 1'b1;
                        end
                        r_last_grant <= r_grant;
                        r_state      <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4_wr_arbiter
// Description : Self-checking bench for axi4_wr_arbiter. Drives both masters
//               and acts as the downstream slave. Expected grants, payloads
//               and sticky error flags come from a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_wr_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 8;
    localparam int SW = DW / 8;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // upstream stimulus, indexed by master
    logic [IW-1:0] s_awid    [2];
    logic [AW-1:0] s_awaddr  [2];
    logic [7:0]    s_awlen   [2];
    logic [2:0]    s_awsize  [2];
    logic [1:0]    s_awburst [2];
    logic [1:0]    s_awvalid;
    logic [DW-1:0] s_wdata   [2];
    logic [SW-1:0] s_wstrb   [2];
    logic [1:0]    s_wlast;
    logic [1:0]    s_wvalid;
    logic [1:0]    s_bready;
    wire  [1:0]    s_awready;
    wire  [1:0]    s_wready;
    wire  [1:0]    s_bvalid;
    wire  [IW-1:0] s_bid     [2];
    wire  [1:0]    s_bresp   [2];

    // downstream
    wire  [IW-1:0] m_awid;
    wire  [AW-1:0] m_awaddr;
    wire  [7:0]    m_awlen;
    wire  [2:0]    m_awsize;
    wire  [1:0]    m_awburst;
    wire           m_awvalid;
    logic          m_awready;
    wire  [DW-1:0] m_wdata;
    wire  [SW-1:0] m_wstrb;
    wire           m_wlast;
    wire           m_wvalid;
    logic          m_wready;
    logic [IW-1:0] m_bid;
    logic [1:0]    m_bresp;
    logic          m_bvalid;
    wire           m_bready;
    wire           busy;
    wire           err_len;
    wire           err_id;

    axi4_wr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clock(clock), .reset(reset),
        .S0_AWID(s_awid[0]), .S0_AWADDR(s_awaddr[0]), .S0_AWLEN(s_awlen[0]),
        .S0_AWSIZE(s_awsize[0]), .S0_AWBURST(s_awburst[0]), .S0_AWVALID(s_awvalid[0]),
        .S0_AWREADY(s_awready[0]),
        .S0_WDATA(s_wdata[0]), .S0_WSTRB(s_wstrb[0]), .S0_WLAST(s_wlast[0]),
        .S0_WVALID(s_wvalid[0]), .S0_WREADY(s_wready[0]),
        .S0_BID(s_bid[0]), .S0_BRESP(s_bresp[0]), .S0_BVALID(s_bvalid[0]),
        .S0_BREADY(s_bready[0]),
        .S1_AWID(s_awid[1]), .S1_AWADDR(s_awaddr[1]), .S1_AWLEN(s_awlen[1]),
        .S1_AWSIZE(s_awsize[1]), .S1_AWBURST(s_awburst[1]), .S1_AWVALID(s_awvalid[1]),
        .S1_AWREADY(s_awready[1]),
        .S1_WDATA(s_wdata[1]), .S1_WSTRB(s_wstrb[1]), .S1_WLAST(s_wlast[1]),
        .S1_WVALID(s_wvalid[1]), .S1_WREADY(s_wready[1]),
        .S1_BID(s_bid[1]), .S1_BRESP(s_bresp[1]), .S1_BVALID(s_bvalid[1]),
        .S1_BREADY(s_bready[1]),
        .M_AWID(m_awid), .M_AWADDR(m_awaddr), .M_AWLEN(m_awlen), .M_AWSIZE(m_awsize),
        .M_AWBURST(m_awburst), .M_AWVALID(m_awvalid), .M_AWREADY(m_awready),
        .M_WDATA(m_wdata), .M_WSTRB(m_wstrb), .M_WLAST(m_wlast), .M_WVALID(m_wvalid),
        .M_WREADY(m_wready),
        .M_BID(m_bid), .M_BRESP(m_bresp), .M_BVALID(m_bvalid), .M_BREADY(m_bready),
        .busy(busy), .err_len(err_len), .err_id(err_id)
    );

    int checks = 0;
    int errors = 0;

    // transaction-level reference state
    int exp_last    = 1;
    bit exp_err_len = 1'b0;
    bit exp_err_id  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        s_awvalid = 2'b00; s_wvalid = 2'b00; s_wlast = 2'b00; s_bready = 2'b00;
        m_awready = 1'b0;  m_wready = 1'b0;  m_bvalid = 1'b0;
        m_bid = '0;        m_bresp = 2'b00;
    endtask

    task automatic rand_master(input int m, input int len);
        s_awid[m]    = IW'($urandom);
        s_awaddr[m]  = AW'($urandom);
        s_awlen[m]   = 8'(len);
        s_awsize[m]  = 3'd2;
        s_awburst[m] = 2'd1;
    endtask

    // Inputs held in a hostile state: every ready/valid high, no AW request.
    // Any VALID/READY output that is nonzero betrays a non-IDLE state.
    task automatic check_quiet(input string tag);
        s_awvalid = 2'b00; s_wvalid = 2'b11; s_bready = 2'b11;
        m_awready = 1'b1;  m_wready = 1'b1;  m_bvalid = 1'b1;
        #1;
        chk(tag, {s_awready, s_wready, s_bvalid, m_awvalid, m_wvalid, m_bready,
                  busy, err_len, err_id}, 64'd0);
    endtask

    // One write transaction. The winner is predicted from the round-robin rule;
    // the other requester (if any) must stay held off throughout.
    task automatic xact(input bit req0, input bit req1, input int nbeats,
                        input logic [IW-1:0] bid_ret, input logic [1:0] bresp,
                        input int aw_stall, input bit w_toggle, input int b_delay,
                        input int abort_after);
        int w, o, idx, cyc;
        bit last, abort;
        logic [DW-1:0] dat [16];
        logic [SW-1:0] stb [16];
        w = (req0 && req1) ? (exp_last == 0 ? 1 : 0) : (req1 ? 1 : 0);
        o = 1 - w;
        for (int i = 0; i < 16; i++) begin
            dat[i] = DW'($urandom);
            stb[i] = SW'($urandom);
        end

        // IDLE: request seen, nothing forwarded yet
        @(negedge clock);
        s_awvalid = {req1, req0};
        m_awready = 1'b1;
        #1;
        chk("idle_m_awvalid", m_awvalid, 0);
        chk("idle_awready", s_awready, 0);
        chk("idle_busy", busy, 0);

        // ADDR
        cyc = 0;
        do begin
            @(negedge clock);
            m_awready = (cyc >= aw_stall);
            #1;
            chk("aw_valid", m_awvalid, 1);
            chk("aw_addr", m_awaddr, s_awaddr[w]);
            chk("aw_id", m_awid, s_awid[w]);
            chk("aw_len", m_awlen, s_awlen[w]);
            chk("aw_ready_g", s_awready[w], m_awready);
            chk("aw_ready_ng", s_awready[o], 0);
            chk("aw_busy", busy, 1);
            cyc++;
        end while (!m_awready);

        // DATA: the other master offers bogus beats that must be held off
        idx = 0; cyc = 0; abort = 1'b0;
        while (idx < nbeats && !abort) begin
            @(negedge clock);
            s_awvalid[w] = 1'b0;
            m_awready    = 1'b1;
            last         = (idx == nbeats - 1);
            s_wvalid     = 2'b11;
            s_wdata[w]   = dat[idx];  s_wstrb[w] = stb[idx];  s_wlast[w] = last;
            s_wdata[o]   = ~dat[idx]; s_wstrb[o] = ~stb[idx]; s_wlast[o] = 1'b1;
            m_wready     = w_toggle ? (cyc % 2 == 1) : 1'b1;
            #1;
            chk("w_valid", m_wvalid, 1);
            chk("w_data", m_wdata, dat[idx]);
            chk("w_strb", m_wstrb, stb[idx]);
            chk("w_last", m_wlast, last);
            chk("w_ready_g", s_wready[w], m_wready);
            chk("w_ready_ng", s_wready[o], 0);
            chk("w_awready", s_awready, 0);
            chk("w_busy", busy, 1);
            if (m_wready) begin
                if (last && idx != int'(s_awlen[w])) exp_err_len = 1'b1;
                if (!last && idx == int'(s_awlen[w])) exp_err_len = 1'b1;
                idx++;
            end
            if (abort_after >= 0 && idx == abort_after) abort = 1'b1;
            cyc++;
        end

        if (abort) begin
            @(negedge clock);
            reset = 1'b1;
            clear_inputs();
            @(negedge clock);
            check_quiet("abort_quiet");
            exp_last = 1; exp_err_len = 1'b0; exp_err_id = 1'b0;
            reset = 1'b0;
            clear_inputs();
            return;
        end

        // RESP: only the granted master's BREADY is high, so a misrouted
        // M_BREADY shows up as a mismatch.
        for (cyc = 0; cyc <= b_delay; cyc++) begin
            @(negedge clock);
            s_wvalid    = 2'b00;
            s_bready[w] = 1'b1; s_bready[o] = 1'b0;
            m_bvalid    = (cyc == b_delay);
            m_bid       = bid_ret;
            m_bresp     = bresp;
            #1;
            chk("b_m_bready", m_bready, 1);
            chk("b_valid_g", s_bvalid[w], m_bvalid);
            chk("b_valid_ng", s_bvalid[o], 0);
            chk("b_m_wvalid", m_wvalid, 0);
            chk("b_busy", busy, 1);
            if (m_bvalid) begin
                chk("b_id", s_bid[w], bid_ret);
                chk("b_resp", s_bresp[w], bresp);
            end
        end
        if (bid_ret != s_awid[w]) exp_err_id = 1'b1;
        exp_last = w;

        // back in IDLE
        @(negedge clock);
        clear_inputs();
        #1;
        chk("end_busy", busy, 0);
        chk("end_err_len", err_len, exp_err_len);
        chk("end_err_id", err_id, exp_err_id);
    endtask

    initial begin
        int len, r;
        for (int m = 0; m < 2; m++) begin
            rand_master(m, 0);
            s_wdata[m] = '0;
            s_wstrb[m] = '0;
        end
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_quiet("reset_quiet");
        clear_inputs();
        reset = 1'b0;

        // simultaneous requests: 0, then waiting 1, then 0 again
        rand_master(0, 2); rand_master(1, 1);
        xact(1, 1, 3, s_awid[0], 2'd0, 0, 0, 0, -1);
        xact(0, 1, 2, s_awid[1], 2'd0, 0, 0, 0, -1);
        rand_master(0, 0); rand_master(1, 3);
        xact(1, 1, 1, s_awid[0], 2'd0, 0, 0, 0, -1);

        // master 0 alone, 4-beat burst at 0x1000
        rand_master(0, 3);
        s_awaddr[0] = 32'h0000_1000;
        xact(1, 0, 4, s_awid[0], 2'd0, 0, 0, 0, -1);

        // downstream backpressure on all three channels
        rand_master(1, 5);
        xact(0, 1, 6, s_awid[1], 2'd2, 3, 1, 5, -1);

        // AWLEN=1 with WLAST on the third beat, then a clean burst (sticky)
        rand_master(0, 1);
        xact(1, 0, 3, s_awid[0], 2'd0, 0, 0, 0, -1);
        rand_master(1, 2);
        xact(0, 1, 3, s_awid[1], 2'd0, 1, 0, 1, -1);

        // wrong BID returned
        rand_master(0, 1);
        s_awid[0] = 8'h5A;
        xact(1, 0, 2, 8'h3C, 2'd0, 0, 0, 2, -1);

        // reset after two of eight beats, then master 1 serviced normally
        rand_master(0, 7);
        xact(1, 0, 8, s_awid[0], 2'd0, 0, 0, 0, 2);
        rand_master(1, 2);
        xact(0, 1, 3, s_awid[1], 2'd1, 0, 1, 1, -1);

        // randomized mix of requesters, lengths and stalls
        for (int t = 0; t < 8; t++) begin
            r   = int'($urandom_range(1, 3));
            len = int'($urandom_range(0, 4));
            rand_master(0, len);
            rand_master(1, len);
            xact(r[0], r[1], len + 1, ((r == 3) ? (exp_last == 0 ? s_awid[1] : s_awid[0])
                                                : (r[1] ? s_awid[1] : s_awid[0])),
                 2'($urandom), int'($urandom_range(0, 2)), 1'($urandom),
                 int'($urandom_range(0, 3)), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
